// File: rtl/jam_pkg.sv
// Shared JAM definitions: table geometry, result widths and the server state encoding.
package jam_pkg;
  localparam int N          = 8;
  localparam int COST_W     = 7;
  localparam int MIN_COST_W = 10;
  localparam int MATCH_W    = 4;
  localparam int IDX_W      = 3;
  localparam int ADDR_W     = 2 * IDX_W;
  localparam int DEPTH      = N * N;

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} jam_state_e;
  typedef logic [COST_W-1:0] cost_t;
endpackage

// File: rtl/jam_cost_server_if.sv
// Load stream, cost lookup and result capture signals between loader/engine and the server.
interface jam_cost_server_if;
  import jam_pkg::*;
  logic                  load_start;
  logic                  load_valid;
  logic                  load_ready;
  cost_t                 load_data;
  logic                  load_last;
  logic                  load_err;
  logic                  table_ready;
  logic [IDX_W-1:0]      W;
  logic [IDX_W-1:0]      J;
  cost_t                 Cost;
  logic                  Valid;
  logic [MIN_COST_W-1:0] MinCost;
  logic [MATCH_W-1:0]    MatchCount;
  logic [MIN_COST_W-1:0] res_min_cost;
  logic [MATCH_W-1:0]    res_match_count;
  logic                  done;

  modport slave (
    input  load_start, load_valid, load_data, load_last, W, J, Valid, MinCost, MatchCount,
    output load_ready, load_err, table_ready, Cost, res_min_cost, res_match_count, done
  );
  modport master (
    output load_start, load_valid, load_data, load_last, W, J, Valid, MinCost, MatchCount,
    input  load_ready, load_err, table_ready, Cost, res_min_cost, res_match_count, done
  );
endinterface

// File: rtl/jam_cost_table.sv
// 64-entry cost storage: synchronous write, registered read that returns 0 when not enabled.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  cost_t             wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output cost_t             rd_data
);
  // Storage is deliberately unreset; nothing reads it until a full load completes.
  cost_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end
endmodule

// File: rtl/jam_cost_server.sv
// JAM cost server: loads the worker/job cost table, serves lookups and captures the result.
module jam_cost_server
  import jam_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_n,
  jam_cost_server_if.slave   bus
);
  jam_state_e        state, state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept, last_slot, serving, start, capture;

  assign serving   = (state == SERVE) || (state == DONE);
  assign accept    = (state == LOAD) && bus.load_valid;
  assign last_slot = &wr_ptr;
  assign start     = bus.load_start && ((state == IDLE) || serving);
  // load_start beats a same-cycle Valid
  assign capture   = (state == SERVE) && bus.Valid && !bus.load_start;

  assign bus.load_ready = (state == LOAD);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.load_start) state_nx = LOAD;
      LOAD:  if (accept) begin
               if (last_slot && bus.load_last)      state_nx = SERVE;
               else if (last_slot || bus.load_last) state_nx = IDLE;
             end
      SERVE: if (bus.load_start) state_nx = LOAD;
             else if (bus.Valid) state_nx = DONE;
      DONE:  if (bus.load_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state               <= IDLE;
      wr_ptr              <= '0;
      bus.load_err        <= 1'b0;
      bus.table_ready     <= 1'b0;
      bus.done            <= 1'b0;
      bus.res_min_cost    <= '0;
      bus.res_match_count <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        wr_ptr              <= '0;
        bus.load_err        <= 1'b0;
        bus.table_ready     <= 1'b0;
        bus.done            <= 1'b0;
        bus.res_min_cost    <= '0;
        bus.res_match_count <= '0;
      end else if (accept) begin
        if (!last_slot) wr_ptr <= wr_ptr + 1'b1;
        if (last_slot && bus.load_last)           bus.table_ready <= 1'b1;
        else if (last_slot || bus.load_last)      bus.load_err    <= 1'b1;
      end
      if (capture) begin
        bus.res_min_cost    <= bus.MinCost;
        bus.res_match_count <= bus.MatchCount;
        bus.done            <= 1'b1;
      end
    end
  end

  jam_cost_table u_table (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.load_data),
    .rd_en   (serving && !bus.load_start),
    .rd_addr ({bus.W, bus.J}),
    .rd_data (bus.Cost)
  );
endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server: load, backpressure, load errors, capture, reload.
module tb_jam_cost_server;
  import jam_pkg::*;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 CLK = ~CLK;

  jam_cost_server_if bus ();

  jam_cost_server dut (.CLK(CLK), .RST_n(RST_n), .bus(bus));

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entry k carries (k+base)%100; load_last is raised on entry last_idx (-1 = never).
  task automatic do_load(input int base, input bit toggle, input int last_idx,
                         input int stop_at, output int accepts, output bit tr_early);
    int  cyc;
    bit  acc;
    bit  was_last;
    accepts  = 0;
    cyc      = 0;
    tr_early = 1'b0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    while (accepts < stop_at && cyc < 400) begin
      bus.load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.load_data  = cost_t'((accepts + base) % 100);
      bus.load_last  = (accepts == last_idx);
      acc      = bus.load_valid && bus.load_ready;
      was_last = bus.load_last;
      if (bus.table_ready) tr_early = 1'b1;
      tick();
      cyc++;
      if (acc) begin
        accepts++;
        if (was_last) break;
      end
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("load_bound", int'(cyc < 400), 1);
  endtask

  task automatic rd(input int w, input int j, input int exp, input string tag);
    bus.W = 3'(w);
    bus.J = 3'(j);
    tick();
    chk(tag, int'(bus.Cost), exp);
  endtask

  int acc_n;
  bit early;

  initial begin
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
    bus.W = '0; bus.J = '0; bus.Valid = 0; bus.MinCost = '0; bus.MatchCount = '0;

    // reset state
    #12;
    chk("rst_load_ready", int'(bus.load_ready), 0);
    chk("rst_table_ready", int'(bus.table_ready), 0);
    chk("rst_cost", int'(bus.Cost), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_res_min", int'(bus.res_min_cost), 0);
    RST_n = 1'b1;
    tick();

    // 1: reset in the middle of a load
    do_load(0, 1'b0, 63, 20, acc_n, early);
    chk("t1_accepts", acc_n, 20);
    chk("t1_ready_before", int'(bus.load_ready), 1);
    #2 RST_n = 1'b0;
    #1;
    chk("t1_ready_async", int'(bus.load_ready), 0);
    chk("t1_err_async", int'(bus.load_err), 0);
    chk("t1_cost_async", int'(bus.Cost), 0);
    tick();
    RST_n = 1'b1;
    tick(); tick();
    chk("t1_idle_ready", int'(bus.load_ready), 0);
    chk("t1_table_ready", int'(bus.table_ready), 0);

    // 2: full load, k%100
    do_load(0, 1'b0, 63, 64, acc_n, early);
    chk("t2_accepts", acc_n, 64);
    chk("t2_table_ready", int'(bus.table_ready), 1);
    chk("t2_load_ready", int'(bus.load_ready), 0);
    chk("t2_load_err", int'(bus.load_err), 0);
    rd(3, 5, 29, "t2_cost_3_5");
    rd(7, 7, 63, "t2_cost_7_7");
    rd(0, 0, 0, "t2_cost_0_0");

    // 3: backpressure with a different data pattern
    do_load(30, 1'b1, 63, 64, acc_n, early);
    chk("t3_accepts", acc_n, 64);
    chk("t3_tr_early", int'(early), 0);
    chk("t3_table_ready", int'(bus.table_ready), 1);
    rd(3, 5, 59, "t3_cost_3_5");
    rd(7, 7, 93, "t3_cost_7_7");
    rd(0, 0, 30, "t3_cost_0_0");

    // 4: early load_last, then missing load_last
    do_load(0, 1'b0, 10, 64, acc_n, early);
    chk("t4_accepts", acc_n, 11);
    chk("t4_load_err", int'(bus.load_err), 1);
    chk("t4_load_ready", int'(bus.load_ready), 0);
    chk("t4_table_ready", int'(bus.table_ready), 0);
    rd(3, 5, 0, "t4_cost_3_5");
    rd(0, 1, 0, "t4_cost_0_1");
    do_load(0, 1'b0, -1, 64, acc_n, early);
    chk("t4b_load_err", int'(bus.load_err), 1);
    chk("t4b_table_ready", int'(bus.table_ready), 0);
    rd(7, 7, 0, "t4b_cost_7_7");

    // 5: result capture, second Valid ignored
    do_load(0, 1'b0, 63, 64, acc_n, early);
    chk("t5_load_err", int'(bus.load_err), 0);
    chk("t5_done_before", int'(bus.done), 0);
    bus.Valid = 1'b1; bus.MinCost = 10'd320; bus.MatchCount = 4'd2;
    tick();
    bus.Valid = 1'b0;
    chk("t5_res_min", int'(bus.res_min_cost), 320);
    chk("t5_res_cnt", int'(bus.res_match_count), 2);
    chk("t5_done", int'(bus.done), 1);
    bus.Valid = 1'b1; bus.MinCost = 10'd100; bus.MatchCount = 4'd1;
    tick();
    bus.Valid = 1'b0;
    chk("t5_res_min_keep", int'(bus.res_min_cost), 320);
    chk("t5_res_cnt_keep", int'(bus.res_match_count), 2);
    rd(7, 7, 63, "t5_cost_done");

    // 6: load_start and Valid together in DONE
    bus.load_start = 1'b1; bus.Valid = 1'b1; bus.MinCost = 10'd5; bus.MatchCount = 4'd3;
    tick();
    bus.load_start = 1'b0; bus.Valid = 1'b0;
    chk("t6_done", int'(bus.done), 0);
    chk("t6_res_min", int'(bus.res_min_cost), 0);
    chk("t6_res_cnt", int'(bus.res_match_count), 0);
    chk("t6_load_ready", int'(bus.load_ready), 1);
    chk("t6_table_ready", int'(bus.table_ready), 0);
    rd(7, 7, 0, "t6_cost_zero");
    do_load(50, 1'b0, 63, 64, acc_n, early);
    chk("t6_accepts", acc_n, 64);
    chk("t6_table_ready2", int'(bus.table_ready), 1);
    rd(1, 1, 59, "t6_cost_1_1");
    rd(7, 7, 13, "t6_cost_7_7");
    rd(3, 5, 79, "t6_cost_3_5");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
